// File: rtl/lte_ul_path_pow_meas.sv
// Uplink per-antenna mean power meter.
// Taps the antenna-TDM uplink sample stream without touching it. It averages
// |I|^2+|Q|^2 over 2^WIN_LOG2 rounds per antenna and publishes one 32-bit
// result per antenna with an update pulse.
module lte_ul_path_pow_meas #(
    parameter int WIN_LOG2 = 10
) (
    input  logic        clk,
    input  logic        asy_rst,
    input  logic        i_fram_hd,
    input  logic        i_ant8_sel,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    input  logic        i_clr,
    output logic [31:0] o_ant0_pow,
    output logic [31:0] o_ant1_pow,
    output logic [31:0] o_ant2_pow,
    output logic [31:0] o_ant3_pow,
    output logic [31:0] o_ant4_pow,
    output logic [31:0] o_ant5_pow,
    output logic [31:0] o_ant6_pow,
    output logic [31:0] o_ant7_pow,
    output logic        o_pow_upd,
    output logic        o_align_err
);

    localparam int ACC_W = 33 + WIN_LOG2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DUMP = 2'd2;

    localparam logic [WIN_LOG2-1:0] RND_MAX = '1;

    logic [1:0]          state;
    logic [2:0]          slot_cnt;
    logic [WIN_LOG2-1:0] rnd;
    logic                mode8;

    logic                accept;
    logic                restart;
    logic                last_slot;
    logic                win_end;
    logic                cur_mode;
    logic [2:0]          cur_slot;
    logic [WIN_LOG2-1:0] rnd_eff;

    logic signed [31:0]  ext_i;
    logic signed [31:0]  ext_q;
    logic signed [31:0]  sq_i;
    logic signed [31:0]  sq_q;

    logic                s1_vld;
    logic                s1_load;
    logic                s1_last;
    logic                s1_mode;
    logic [2:0]          s1_slot;
    logic [31:0]         s1_isq;
    logic [31:0]         s1_qsq;

    logic [32:0]         p_sum;
    logic [ACC_W-1:0]    p_ext;
    logic [ACC_W-1:0]    acc [8];
    logic                dump_pend;
    logic                dump_mode;

    logic [31:0]         pow_q [8];

    // The squares of a full-scale -32768 still fit a signed 32-bit product.
    assign ext_i = {{16{i_data[31]}}, i_data[31:16]};
    assign ext_q = {{16{i_data[15]}}, i_data[15:0]};
    assign sq_i  = ext_i * ext_i;
    assign sq_q  = ext_q * ext_q;

    // Classify the sample at the inputs: its slot, restart condition and window end.
    always_comb begin
        cur_slot  = i_fram_hd ? 3'd0 : slot_cnt;
        cur_mode  = i_fram_hd ? i_ant8_sel : mode8;
        accept    = i_data_valid && ((state != ST_IDLE) || i_fram_hd);
        restart   = i_data_valid && i_fram_hd && (state != ST_IDLE) && (slot_cnt != 3'd0);
        rnd_eff   = ((state == ST_IDLE) || restart) ? '0 : rnd;
        last_slot = cur_mode ? (cur_slot == 3'd7) : (cur_slot == 3'd3);
        win_end   = last_slot && (rnd_eff == RND_MAX);
    end

    // Control: FSM, slot/round counters, latched antenna mode and alignment error pulse.
    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            state       <= ST_IDLE;
            slot_cnt    <= 3'd0;
            rnd         <= '0;
            mode8       <= 1'b0;
            o_align_err <= 1'b0;
        end else begin
            o_align_err <= 1'b0;
            if (i_clr) begin
                state    <= ST_IDLE;
                slot_cnt <= 3'd0;
                rnd      <= '0;
            end else if (accept) begin
                if (i_fram_hd) begin
                    mode8 <= i_ant8_sel;
                end
                o_align_err <= restart;
                slot_cnt    <= last_slot ? 3'd0 : cur_slot + 3'd1;
                rnd         <= last_slot ? rnd_eff + WIN_LOG2'(1) : rnd_eff;
                state       <= win_end ? ST_DUMP : ST_ACC;
            end else if (state == ST_DUMP) begin
                state <= ST_ACC;
            end
        end
    end

    // Stage 1: register the squares with the slot, first-round and window-end tags.
    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            s1_vld  <= 1'b0;
            s1_load <= 1'b0;
            s1_last <= 1'b0;
            s1_mode <= 1'b0;
            s1_slot <= 3'd0;
            s1_isq  <= 32'd0;
            s1_qsq  <= 32'd0;
        end else begin
            s1_vld  <= accept && !i_clr;
            s1_load <= (rnd_eff == '0);
            s1_last <= win_end;
            s1_mode <= cur_mode;
            s1_slot <= cur_slot;
            s1_isq  <= sq_i;
            s1_qsq  <= sq_q;
        end
    end

    assign p_sum = {1'b0, s1_isq} + {1'b0, s1_qsq};
    assign p_ext = {{WIN_LOG2{1'b0}}, p_sum};

    // Stage 2: first round of a window reloads its slot accumulator, later rounds add.
    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            for (int k = 0; k < 8; k++) begin
                acc[k] <= '0;
            end
            dump_pend <= 1'b0;
            dump_mode <= 1'b0;
        end else begin
            dump_pend <= s1_vld && s1_last;
            dump_mode <= s1_mode;
            if (s1_vld) begin
                acc[s1_slot] <= s1_load ? p_ext : acc[s1_slot] + p_ext;
            end
        end
    end

    // Stage 3: publish the window means; this edge coincides with the next window's first load.
    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            for (int k = 0; k < 8; k++) begin
                pow_q[k] <= 32'd0;
            end
            o_pow_upd <= 1'b0;
        end else begin
            o_pow_upd <= dump_pend;
            if (dump_pend) begin
                for (int k = 0; k < 8; k++) begin
                    pow_q[k] <= ((k >= 4) && !dump_mode) ? 32'd0 : acc[k][WIN_LOG2 +: 32];
                end
            end
        end
    end

    assign o_ant0_pow = pow_q[0];
    assign o_ant1_pow = pow_q[1];
    assign o_ant2_pow = pow_q[2];
    assign o_ant3_pow = pow_q[3];
    assign o_ant4_pow = pow_q[4];
    assign o_ant5_pow = pow_q[5];
    assign o_ant6_pow = pow_q[6];
    assign o_ant7_pow = pow_q[7];

endmodule

// File: tb/tb_lte_ul_path_pow_meas.sv
// Testbench for lte_ul_path_pow_meas.
// A sample-level model tracks windows as plain per-antenna sums and sample counts. It schedules
// the expected result vector, update pulse and alignment pulse by cycle number. A negedge process
// compares every cycle, and hand-computed literals pin both the DUT and the model.
module tb_lte_ul_path_pow_meas;

    localparam int WIN_LOG2 = 2;
    localparam int ROUNDS   = 1 << WIN_LOG2;

    typedef logic [7:0][31:0] pow_vec_t;

    logic        clk = 1'b0;
    logic        asy_rst;
    logic        i_fram_hd = 1'b0;
    logic        i_ant8_sel = 1'b0;
    logic [31:0] i_data = 32'd0;
    logic        i_data_valid = 1'b0;
    logic        i_clr = 1'b0;
    logic [31:0] o_ant0_pow, o_ant1_pow, o_ant2_pow, o_ant3_pow;
    logic [31:0] o_ant4_pow, o_ant5_pow, o_ant6_pow, o_ant7_pow;
    logic        o_pow_upd;
    logic        o_align_err;

    lte_ul_path_pow_meas #(.WIN_LOG2(WIN_LOG2)) dut (
        .clk         (clk),
        .asy_rst     (asy_rst),
        .i_fram_hd   (i_fram_hd),
        .i_ant8_sel  (i_ant8_sel),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .i_clr       (i_clr),
        .o_ant0_pow  (o_ant0_pow),
        .o_ant1_pow  (o_ant1_pow),
        .o_ant2_pow  (o_ant2_pow),
        .o_ant3_pow  (o_ant3_pow),
        .o_ant4_pow  (o_ant4_pow),
        .o_ant5_pow  (o_ant5_pow),
        .o_ant6_pow  (o_ant6_pow),
        .o_ant7_pow  (o_ant7_pow),
        .o_pow_upd   (o_pow_upd),
        .o_align_err (o_align_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int upd_seen = 0;

    // Model state: window-level view of the stream.
    bit       m_idle = 1'b1;
    bit       m_mode8 = 1'b0;
    int       m_cnt = 0;
    longint   m_sum [8];
    pow_vec_t pow_sched [int];
    bit       err_sched [int];

    pow_vec_t exp_pow = '0;
    pow_vec_t act_pow;
    bit       e_upd;
    bit       e_err;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic longint pw(input logic [31:0] d);
        longint i;
        longint q;
        i = longint'($signed(d[31:16]));
        q = longint'($signed(d[15:0]));
        return i * i + q * q;
    endfunction

    function automatic int model_slot();
        int n;
        n = m_mode8 ? 8 : 4;
        return m_idle ? 0 : (m_cnt % n);
    endfunction

    task automatic clear_sums();
        for (int k = 0; k < 8; k++) m_sum[k] = 0;
    endtask

    // One input cycle seen by the model; t is the cycle the sample sits on the inputs.
    task automatic model_step(input int t, input bit hd, input bit sel, input logic [31:0] d,
                              input bit vld, input bit clr);
        int n;
        int slot;
        pow_vec_t v;
        if (clr) begin
            m_idle = 1'b1;
            return;
        end
        if (!vld) return;
        if (m_idle) begin
            if (!hd) return;
            m_idle  = 1'b0;
            m_mode8 = sel;
            m_cnt   = 0;
            clear_sums();
        end else if (hd) begin
            n = m_mode8 ? 8 : 4;
            if ((m_cnt % n) != 0) begin
                err_sched[t + 1] = 1'b1;
                m_cnt = 0;
                clear_sums();
            end
            m_mode8 = sel;
        end
        n    = m_mode8 ? 8 : 4;
        slot = m_cnt % n;
        m_sum[slot] += pw(d);
        m_cnt++;
        if (m_cnt == n * ROUNDS) begin
            for (int k = 0; k < 8; k++) v[k] = (k < n) ? 32'(m_sum[k] / ROUNDS) : 32'd0;
            pow_sched[t + 3] = v;
            m_cnt = 0;
            clear_sums();
        end
    endtask

    task automatic applyStimulus(input bit hd, input bit sel, input logic [31:0] d,
                                 input bit vld, input bit clr, input bit rst);
        @(posedge clk);
        #1;
        i_fram_hd    = hd;
        i_ant8_sel   = sel;
        i_data       = d;
        i_data_valid = vld;
        i_clr        = clr;
        asy_rst      = rst;
        if (rst) begin
            m_idle = 1'b1;
            m_cnt  = 0;
            pow_sched.delete();
            err_sched.delete();
        end else begin
            model_step(cyc, hd, sel, d, vld, clr);
        end
    endtask

    task automatic send(input bit hd, input bit sel, input logic [31:0] d, input bit gaps);
        if (gaps) begin
            for (int g = 0; g < 6 && ($urandom_range(1, 0) == 1); g++)
                applyStimulus($urandom_range(1, 0) == 1, sel, $urandom, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(hd, sel, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, i_ant8_sel, $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pin(input string tag, input pow_vec_t lit);
        @(negedge clk);
        #1;
        checkOutput({tag, "_dut"}, {o_ant7_pow, o_ant6_pow, o_ant5_pow, o_ant4_pow,
                                    o_ant3_pow, o_ant2_pow, o_ant1_pow, o_ant0_pow}, lit);
        checkOutput({tag, "_model"}, exp_pow, lit);
    endtask

    function automatic logic [31:0] pat_a(input int k);
        logic [15:0] iv;
        iv = 16'(100 * (k + 1));
        return {iv, 16'hFFCE};
    endfunction

    function automatic logic [31:0] pat_b(input int k);
        logic [15:0] iv;
        iv = 16'(200 * (k + 1));
        return {iv, 16'h0000};
    endfunction

    function automatic logic [31:0] pat_c(input int k);
        logic [15:0] iv;
        iv = 16'(1000 * (k + 1));
        return {iv, 16'h0000};
    endfunction

    // Per-cycle compare of every output against the model schedule.
    always @(negedge clk) begin
        if (asy_rst) begin
            exp_pow = '0;
            e_upd   = 1'b0;
            e_err   = 1'b0;
        end else begin
            e_upd = pow_sched.exists(cyc);
            if (e_upd) begin
                exp_pow = pow_sched[cyc];
                pow_sched.delete(cyc);
            end
            e_err = err_sched.exists(cyc);
            if (e_err) err_sched.delete(cyc);
        end
        act_pow = {o_ant7_pow, o_ant6_pow, o_ant5_pow, o_ant4_pow,
                   o_ant3_pow, o_ant2_pow, o_ant1_pow, o_ant0_pow};
        checkOutput("pow_regs", act_pow, exp_pow);
        checkOutput("pow_upd", o_pow_upd, e_upd);
        checkOutput("align_err", o_align_err, e_err);
        if (o_pow_upd === 1'b1) upd_seen++;
    end

    pow_vec_t lit_a, lit_b, lit_c, lit_full, lit_zero;
    int base;

    initial begin
        lit_a    = {32'd642500, 32'd492500, 32'd362500, 32'd252500,
                    32'd162500, 32'd92500, 32'd42500, 32'd12500};
        lit_b    = {32'd2560000, 32'd1960000, 32'd1440000, 32'd1000000,
                    32'd640000, 32'd360000, 32'd160000, 32'd40000};
        lit_c    = {32'd0, 32'd0, 32'd0, 32'd0,
                    32'd16000000, 32'd9000000, 32'd4000000, 32'd1000000};
        lit_full = {8{32'h8000_0000}};
        lit_zero = '0;
        clear_sums();
        asy_rst = 1'b1;

        // Reset with random stimulus, then no update before a frame header.
        for (int c = 0; c < 10; c++)
            applyStimulus($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom,
                          $urandom_range(1, 0) == 1, 1'b0, 1'b1);
        pin("reset_pow", lit_zero);
        applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 30; c++) send(1'b0, 1'b1, $urandom, 1'b0);
        idle(4);
        checkOutput("no_upd_before_hdr", upd_seen, 0);

        // 8 antennas, continuous data, three windows.
        base = upd_seen;
        for (int r = 0; r < 3 * ROUNDS; r++)
            for (int k = 0; k < 8; k++) send(k == 0, 1'b1, pat_a(k), 1'b0);
        idle(4);
        pin("t2_pow", lit_a);
        checkOutput("t2_upd_count", upd_seen - base, 3);

        // Full-scale negative I and Q.
        for (int r = 0; r < ROUNDS; r++)
            for (int k = 0; k < 8; k++) send(k == 0, 1'b1, 32'h8000_8000, 1'b0);
        idle(4);
        pin("t3_pow", lit_full);

        // Same as continuous test with random gaps in valid.
        base = upd_seen;
        for (int r = 0; r < 2 * ROUNDS; r++)
            for (int k = 0; k < 8; k++) send(k == 0, 1'b1, pat_a(k), 1'b1);
        idle(4);
        pin("t4_pow", lit_a);
        checkOutput("t4_upd_count", upd_seen - base, 2);

        // Misaligned frame header at slot 5.
        base = upd_seen;
        for (int j = 0; j < 13; j++) send((j % 8) == 0, 1'b1, $urandom, 1'b0);
        checkOutput("t5_slot_before_hdr", model_slot(), 5);
        send(1'b1, 1'b1, pat_b(0), 1'b0);
        idle(4);
        pin("t5_hold", lit_a);
        checkOutput("t5_no_upd", upd_seen - base, 0);
        for (int j = 1; j < 8 * ROUNDS; j++) send((j % 8) == 0, 1'b1, pat_b(j % 8), 1'b0);
        idle(4);
        pin("t5_after", lit_b);
        checkOutput("t5_upd_count", upd_seen - base, 1);

        // 4 antennas, then clear mid-window.
        base = upd_seen;
        for (int r = 0; r < 2 * ROUNDS; r++)
            for (int k = 0; k < 4; k++) send(k == 0, 1'b0, pat_c(k), 1'b0);
        idle(4);
        pin("t6_pow", lit_c);
        checkOutput("t6_upd_count", upd_seen - base, 2);
        base = upd_seen;
        for (int j = 0; j < 7; j++) send((j % 4) == 0, 1'b0, $urandom, 1'b0);
        applyStimulus(1'b1, 1'b0, $urandom, 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 20; j++) send(1'b0, 1'b0, $urandom, 1'b0);
        idle(4);
        checkOutput("t6_clr_no_upd", upd_seen - base, 0);
        pin("t6_clr_hold", lit_c);
        for (int r = 0; r < ROUNDS; r++)
            for (int k = 0; k < 4; k++) send(k == 0, 1'b0, pat_c(k), 1'b0);
        idle(4);
        checkOutput("t6_restart_upd", upd_seen - base, 1);
        pin("t6_restart_pow", lit_c);

        // Reset in the middle of a window clears the outputs.
        base = upd_seen;
        for (int j = 0; j < 20; j++) send((j % 8) == 0, 1'b1, pat_a(j % 8), 1'b0);
        for (int c = 0; c < 3; c++)
            applyStimulus($urandom_range(1, 0) == 1, 1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        pin("midrst_pow", lit_zero);
        applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 12; j++) send(1'b0, 1'b1, $urandom, 1'b0);
        idle(4);
        checkOutput("midrst_no_upd", upd_seen - base, 0);

        // Randomised segments: random data, gaps, stray headers and clears.
        for (int s = 0; s < 4; s++) begin
            bit sel;
            bit hd;
            sel = (s % 2) == 0;
            applyStimulus(1'b0, sel, $urandom, 1'b0, 1'b1, 1'b0);
            for (int j = 0; j < 220; j++) begin
                hd = ((model_slot() == 0) && ($urandom_range(3, 0) != 0)) ||
                     ($urandom_range(23, 0) == 0);
                if ($urandom_range(99, 0) == 0)
                    applyStimulus(hd, sel, $urandom, 1'b1, 1'b1, 1'b0);
                else
                    send(hd, sel, $urandom, 1'b1);
            end
            idle(4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
